// File: rtl/program_sequencer_if.sv
// Byte load stream and instruction-memory write port shared by the host
// front-end (master) and the program sequencer (slave).
interface program_sequencer_if;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        o_byte_ready;
    logic [7:0]  o_instr_addr;
    logic [15:0] o_instr;
    logic        o_instr_we;

    modport master (
        output i_byte, i_byte_valid,
        input  o_byte_ready, o_instr_addr, o_instr, o_instr_we
    );

    modport slave (
        input  i_byte, i_byte_valid,
        output o_byte_ready, o_instr_addr, o_instr, o_instr_we
    );
endinterface

// File: rtl/program_sequencer.sv
// FRANK6000 program sequencer: loads a counted byte stream into instruction
// memory, pulses CPU reset, runs until the loop flag or the watchdog fires.
module program_sequencer #(
    parameter int CYC_WIDTH  = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    program_sequencer_if.slave   bus,
    input  logic                 i_start,
    input  logic                 i_rerun,
    input  logic                 i_abort,
    input  logic                 i_loopf,
    input  logic [7:0]           i_WREG,
    output logic                 o_ON,
    output logic                 o_control_en,
    output logic                 o_cpu_rst,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic [7:0]           o_result,
    output logic [CYC_WIDTH-1:0] o_cycles,
    output logic [2:0]           o_state
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_WR    = 3'd4;
    localparam logic [2:0] S_CRST  = 3'd5;
    localparam logic [2:0] S_RUN   = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [CYC_WIDTH-1:0] WDOG_LAST = CYC_WIDTH'(MAX_CYCLES - 1);
    localparam logic [CYC_WIDTH-1:0] SETTLE    = CYC_WIDTH'(2);

    logic [2:0]  state, state_nxt;
    logic [8:0]  remaining;
    logic [7:0]  addr;
    logic [15:0] instr;
    logic        accept;
    logic        loop_hit;
    logic        wdog_hit;
    logic        abort_now;

    assign accept    = bus.i_byte_valid & bus.o_byte_ready;
    // The first two RUN cycles carry a stale fetch, so the loop flag is not trusted yet.
    assign loop_hit  = i_loopf && (o_cycles >= SETTLE);
    assign wdog_hit  = (o_cycles == WDOG_LAST);
    assign abort_now = i_abort && (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_COUNT;
            S_COUNT: if (accept) state_nxt = S_HI;
            S_HI:    if (accept) state_nxt = S_LO;
            S_LO:    if (accept) state_nxt = S_WR;
            S_WR:    state_nxt = (remaining == 9'd1) ? S_CRST : S_HI;
            S_CRST:  state_nxt = S_RUN;
            S_RUN:   if (loop_hit || wdog_hit) state_nxt = S_DONE;
            S_DONE: begin
                if (i_start)      state_nxt = S_COUNT;
                else if (i_rerun) state_nxt = S_CRST;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort_now) state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            addr      <= '0;
            instr     <= '0;
            o_cycles  <= '0;
            o_timeout <= 1'b0;
            o_result  <= '0;
        end else begin
            state <= state_nxt;
            // An abort freezes the datapath, so a pending write never advances the address.
            if (!abort_now) begin
                case (state)
                    S_COUNT: if (accept) begin
                        remaining <= (bus.i_byte == 8'd0) ? 9'd256 : {1'b0, bus.i_byte};
                        addr      <= '0;
                    end
                    S_HI: if (accept) instr[15:8] <= bus.i_byte;
                    S_LO: if (accept) instr[7:0]  <= bus.i_byte;
                    S_WR: begin
                        addr      <= addr + 8'd1;
                        remaining <= remaining - 9'd1;
                    end
                    S_CRST: begin
                        o_cycles  <= '0;
                        o_timeout <= 1'b0;
                    end
                    S_RUN: begin
                        if (loop_hit) begin
                            o_timeout <= 1'b0;
                            o_result  <= i_WREG;
                        end else if (wdog_hit) begin
                            o_timeout <= 1'b1;
                            o_result  <= i_WREG;
                        end else begin
                            o_cycles <= o_cycles + CYC_WIDTH'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_byte_ready = (state == S_COUNT) || (state == S_HI) || (state == S_LO);
    assign bus.o_instr_we   = (state == S_WR);
    assign bus.o_instr_addr = addr;
    assign bus.o_instr      = instr;

    assign o_ON         = (state == S_CRST) || (state == S_RUN);
    assign o_control_en = (state == S_RUN);
    assign o_cpu_rst    = (state == S_CRST);
    assign o_busy       = (state != S_IDLE) && (state != S_DONE);
    assign o_done       = (state == S_DONE);
    assign o_state      = state;
endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboarded bench for program_sequencer: expected writes and run results are
// queued by the stimulus and popped by an independent monitor.
module tb_program_sequencer;
    localparam int CW   = 16;
    localparam int MAXC = 10;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct packed {
        logic [7:0]  result;
        logic [15:0] cycles;
        logic        timeout;
    } run_t;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start, i_rerun, i_abort, i_loopf;
    logic [7:0]    i_WREG;
    logic          o_ON, o_control_en, o_cpu_rst, o_busy, o_done, o_timeout;
    logic [7:0]    o_result;
    logic [CW-1:0] o_cycles;
    logic [2:0]    o_state;

    program_sequencer_if bus ();

    program_sequencer #(.CYC_WIDTH(CW), .MAX_CYCLES(MAXC)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .bus(bus),
        .i_start(i_start), .i_rerun(i_rerun), .i_abort(i_abort),
        .i_loopf(i_loopf), .i_WREG(i_WREG),
        .o_ON(o_ON), .o_control_en(o_control_en), .o_cpu_rst(o_cpu_rst),
        .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
        .o_result(o_result), .o_cycles(o_cycles), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    int vectors    = 0;
    int miscompares = 0;
    int rst_cnt    = 0;
    wr_t  wq[$];
    run_t rq[$];
    logic [15:0] wlist[$];
    logic [7:0]  exp_addr;
    logic [7:0]  last_result;
    logic        done_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: compares every write strobe and every run completion against the queues.
    always @(negedge i_clk) begin
        wr_t  ew;
        run_t er;
        if (bus.o_instr_we) begin
            if (wq.size() == 0) flag_fail("unexpected_write");
            else begin
                ew = wq.pop_front();
                chk("wr_addr", {24'd0, bus.o_instr_addr}, {24'd0, ew.addr});
                chk("wr_data", {16'd0, bus.o_instr}, {16'd0, ew.data});
            end
        end
        if (o_done && !done_q) begin
            if (rq.size() == 0) flag_fail("unexpected_done");
            else begin
                er = rq.pop_front();
                chk("run_result", {24'd0, o_result}, {24'd0, er.result});
                chk("run_cycles", {16'd0, o_cycles}, {16'd0, er.cycles});
                chk("run_timeout", {31'd0, o_timeout}, {31'd0, er.timeout});
            end
        end
        if (o_cpu_rst) rst_cnt <= rst_cnt + 1;
        done_q <= o_done;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            bus.i_byte_valid = 1'b0;
            bus.i_byte       = 8'($urandom);
            tick();
        end
        bus.i_byte       = b;
        bus.i_byte_valid = 1'b1;
        t = 0;
        while (!bus.o_byte_ready && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) flag_fail("byte_ready_timeout");
        tick();
    endtask

    task automatic start_load(input logic with_rerun);
        i_start = 1'b1;
        i_rerun = with_rerun;
        tick();
        i_start = 1'b0;
        i_rerun = 1'b0;
        chk("start_state", {29'd0, o_state}, 32'd1);
        chk("start_ready", {31'd0, bus.o_byte_ready}, 32'd1);
    endtask

    task automatic load(input logic [7:0] cnt, input int maxgap);
        int          n;
        logic [15:0] d;
        wr_t         e;
        n = (cnt == 8'd0) ? 256 : int'(cnt);
        send_byte(cnt, $urandom_range(maxgap, 0));
        for (int i = 0; i < n; i++) begin
            d = (wlist.size() > 0) ? wlist.pop_front() : 16'($urandom);
            e.addr = 8'(i);
            e.data = d;
            wq.push_back(e);
            send_byte(d[15:8], $urandom_range(maxgap, 0));
            send_byte(d[7:0], $urandom_range(maxgap, 0));
        end
        bus.i_byte_valid = 1'b0;
        exp_addr = 8'(n);
    endtask

    task automatic wait_crst();
        int t;
        t = 0;
        while (!o_cpu_rst && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) flag_fail("crst_timeout");
    endtask

    // Reference: the run ends at the first loop flag seen at cycle >= 2, else at MAXC-1 by watchdog.
    task automatic run_prog(input logic [31:0] mask);
        run_t       e;
        int         ex;
        int         rp0;
        logic [7:0] w[MAXC];
        for (int c = 0; c < MAXC; c++) w[c] = 8'($urandom);
        ex = MAXC - 1;
        e.timeout = 1'b1;
        for (int c = 2; c < MAXC; c++) begin
            if (mask[c]) begin
                ex = c;
                e.timeout = 1'b0;
                break;
            end
        end
        e.result = w[ex];
        e.cycles = 16'(ex);
        rq.push_back(e);
        last_result = e.result;

        wait_crst();
        rp0 = rst_cnt;
        chk("crst_on", {31'd0, o_ON}, 32'd1);
        chk("crst_ctrl_en", {31'd0, o_control_en}, 32'd0);
        chk("crst_addr", {24'd0, bus.o_instr_addr}, {24'd0, exp_addr});
        for (int c = 0; c < MAXC; c++) begin
            tick();
            if (c == 0) begin
                chk("run_entry_cycles", {16'd0, o_cycles}, 32'd0);
                chk("run_ctrl_en", {31'd0, o_control_en}, 32'd1);
                chk("run_on", {31'd0, o_ON}, 32'd1);
                chk("run_state", {29'd0, o_state}, 32'd6);
            end
            i_loopf = mask[c];
            i_WREG  = w[c];
        end
        tick();
        i_loopf = 1'b0;
        chk("done_flag", {31'd0, o_done}, 32'd1);
        chk("done_on", {31'd0, o_ON}, 32'd0);
        chk("done_ctrl_en", {31'd0, o_control_en}, 32'd0);
        chk("done_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_pulses", 32'(rst_cnt - rp0), 32'd1);
    endtask

    task automatic rerun();
        i_rerun = 1'b1;
        tick();
        i_rerun = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_outs"}, {16'd0, bus.o_byte_ready, bus.o_instr_we, o_ON, o_control_en,
                             o_cpu_rst, o_busy, o_done, o_timeout, o_state, 5'd0}, 32'd0);
        chk({tag, "_addr"}, {24'd0, bus.o_instr_addr}, 32'd0);
        chk({tag, "_instr"}, {16'd0, bus.o_instr}, 32'd0);
        chk({tag, "_result"}, {24'd0, o_result}, 32'd0);
        chk({tag, "_cycles"}, {16'd0, o_cycles}, 32'd0);
    endtask

    initial begin
        i_rst = 1'b1;
        i_start = 1'b0; i_rerun = 1'b0; i_abort = 1'b0; i_loopf = 1'b0;
        i_WREG = 8'd0;
        bus.i_byte = 8'd0;
        bus.i_byte_valid = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        i_rst = 1'b0;
        tick();

        // Continuous stream 02,A1,05,00,00 then loop flag at 1 (ignored) and 5.
        start_load(1'b0);
        wlist.push_back(16'hA105);
        wlist.push_back(16'h0000);
        load(8'h02, 0);
        run_prog(32'b10_0010);
        rerun();
        run_prog(32'h0);                       // watchdog
        rerun();
        run_prog(32'b10_0000_0000);            // tie at cycle 9: loop flag wins
        rerun();
        run_prog(32'b11);                      // early flags only: timeout

        // Stalled stream between HI and LO bytes.
        start_load(1'b1);                      // start beats rerun in DONE
        begin
            wr_t e;
            e.addr = 8'h00;
            e.data = 16'h1234;
            wq.push_back(e);
        end
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        for (int g = 0; g < 3; g++) begin
            bus.i_byte_valid = 1'b0;
            bus.i_byte = 8'($urandom);
            tick();
            chk("stall_ready", {31'd0, bus.o_byte_ready}, 32'd1);
            chk("stall_no_we", {31'd0, bus.o_instr_we}, 32'd0);
        end
        send_byte(8'h34, 0);
        bus.i_byte_valid = 1'b0;
        exp_addr = 8'h01;
        run_prog(32'($urandom));

        // Count 0: 256 words, address wraps back to 0.
        start_load(1'b0);
        load(8'h00, 0);
        run_prog(32'b100_0000);

        // Randomized load/run/rerun sequences.
        for (int k = 0; k < 6; k++) begin
            start_load(1'($urandom));
            load(8'($urandom_range(6, 1)), 2);
            run_prog(32'($urandom & $urandom & $urandom));
            if ($urandom_range(1, 0) == 1) begin
                rerun();
                run_prog(32'($urandom & $urandom));
            end
        end

        // Abort in the WR cycle.
        start_load(1'b0);
        begin
            wr_t e;
            e.addr = 8'h00;
            e.data = 16'hBEEF;
            wq.push_back(e);
        end
        send_byte(8'h02, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        chk("abort_pre_we", {31'd0, bus.o_instr_we}, 32'd1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        bus.i_byte_valid = 1'b0;
        chk("abort_state", {29'd0, o_state}, 32'd0);
        chk("abort_we", {31'd0, bus.o_instr_we}, 32'd0);
        chk("abort_ready", {31'd0, bus.o_byte_ready}, 32'd0);
        chk("abort_result_kept", {24'd0, o_result}, {24'd0, last_result});
        tick();
        chk("abort_idle_hold", {29'd0, o_state}, 32'd0);

        // Reset in the middle of RUN.
        start_load(1'b0);
        load(8'h01, 1);
        wait_crst();
        repeat (3) tick();
        chk("pre_reset_run", {29'd0, o_state}, 32'd6);
        i_rst = 1'b1;
        tick();
        check_all_zero("run_reset");
        i_rst = 1'b0;
        tick();

        repeat (3) tick();
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
Controller that sequences the FRANK6000 CPU through load, run and halt.
- Accepts a byte stream (valid/ready), assembles 16-bit instructions and writes them into CPU instruction memory via the external port.
- Pulses CPU reset, then enables execution and watches the CPU loop flag to declare completion, with a cycle watchdog.
- Sits between the host/serial front-end and the CPU top level.

Parameters:
CYC_WIDTH, 16, width of run-cycle counter o_cycles
MAX_CYCLES, 1000, watchdog limit in RUN cycles (must be >= 3 and < 2^CYC_WIDTH)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_byte  in  8  load stream data
i_byte_valid  in  1  i_byte valid
o_byte_ready  out  1  sequencer accepts byte this cycle
i_start  in  1  begin load (IDLE or DONE)
i_rerun  in  1  rerun loaded program (DONE only)
i_abort  in  1  abort to IDLE
i_loopf  in  1  CPU loop flag
i_WREG  in  8  CPU working register
o_instr_addr  out  8  instruction memory write address
o_instr  out  16  instruction word
o_instr_we  out  1  instruction memory write enable
o_ON  out  1  CPU uses PC for instruction fetch
o_control_en  out  1  CPU control unit enable
o_cpu_rst  out  1  CPU reset pulse
o_busy  out  1  state not IDLE/DONE
o_done  out  1  high in DONE
o_timeout  out  1  last run ended by watchdog
o_result  out  8  WREG captured at run end
o_cycles  out  CYC_WIDTH  RUN cycles of last/current run
o_state  out  3  current state encoding

Behaviour:
- Single clock domain, synchronous active-high reset. All outputs are registered or decoded from the state register only (no input-to-output combinational path).
- States: IDLE=0, COUNT=1, HI=2, LO=3, WR=4, CRST=5, RUN=6, DONE=7.
- Reset: state IDLE. All outputs 0, including o_instr_addr, o_instr, o_result, o_cycles and o_timeout.
- Byte accept = i_byte_valid & o_byte_ready. o_byte_ready = 1 only in COUNT, HI, LO. Valid without ready is ignored; no buffering.
- IDLE: i_start -> COUNT.
- COUNT: on accept, remaining <= (byte==0) ? 256 : byte (9-bit), o_instr_addr <= 0, go HI.
- HI: on accept, o_instr[15:8] <= byte, go LO.
- LO: on accept, o_instr[7:0] <= byte, go WR.
- WR: one cycle, o_instr_we=1 with stable addr and data. Next edge: o_instr_addr increments (8-bit wrap 0xFF->0x00) and remaining decrements. Then go HI if remaining becomes nonzero, else go CRST.
- Write latency: WR is the cycle immediately after the LO-byte accept edge.
- o_ON: 0 in IDLE, COUNT, HI, LO, WR, DONE; 1 in CRST and RUN.
- CRST: one cycle, o_cpu_rst=1, o_control_en=0. Clears o_cycles and o_timeout. Go RUN.
- RUN: o_control_en=1. o_cycles increments each RUN cycle; entry cycle reads 0.
- RUN qualification: i_loopf is ignored while o_cycles < 2 (instruction fetch settling).
- RUN exit, loop flag: qualified i_loopf -> DONE, o_timeout=0.
- RUN exit, watchdog: o_cycles == MAX_CYCLES-1 with no qualified loopf -> DONE, o_timeout=1.
- RUN exit, simultaneous: loopf and watchdog in the same cycle -> loopf wins, o_timeout=0.
- RUN exit edge: o_result <= i_WREG. o_cycles holds its value.
- DONE: o_done=1, o_control_en=0.
  - i_start -> COUNT (reload).
  - i_rerun -> CRST (same program).
  - Both asserted -> i_start wins.
- i_abort: from any state other than IDLE, next state is IDLE.
  - Priority: abort > everything except i_rst.
  - A pending WR write is dropped: o_instr_we is 0 in the following cycle.
  - Instruction-memory contents already written are unaffected.
  - o_result, o_cycles and o_timeout are retained.
- o_state mirrors the state encoding. o_busy = state in {COUNT..RUN}.

Test Plan:
- Load with continuous valid: bytes 02,A1,05,00,00 -> WR at addr 0 data 0xA105, then WR at addr 1 data 0x0000, then one CRST cycle, then RUN with o_ON=1, o_control_en=1.
- Stalled stream: i_byte_valid low 3 cycles between HI and LO bytes -> no write until LO accepted; ready stays 1; data 0x1234 written correctly.
- Count 0: byte 00 followed by 512 data bytes -> exactly 256 writes at addrs 0x00..0xFF; o_instr_addr wraps to 0x00; then CRST.
- Loopf completion: i_loopf high at o_cycles 1 (ignored) and again at o_cycles 5 with i_WREG=0x2A -> DONE, o_result=0x2A, o_cycles=5, o_timeout=0. Then i_rerun -> one o_cpu_rst pulse, o_cycles restarts at 0.
- Watchdog, MAX_CYCLES=10, i_loopf held 0 -> DONE after the RUN cycle where o_cycles=9, o_timeout=1.
- Watchdog tie: i_loopf rises exactly at o_cycles=9 -> o_timeout=0.
- Abort during WR cycle -> next cycle IDLE, o_instr_we=0, o_byte_ready=0.
- Reset during RUN -> all outputs 0 next cycle.
